// File: rtl/mem_bus_router.sv
// Registered CPU bus router: decodes the address into NSLAVE regions, issues one strobe per transaction
// and returns read data/status. Define BUS_TIMEOUT_EN to abort stalled slaves with an m_err completion.
module mem_bus_router #(
    parameter int                       NSLAVE       = 4,
    parameter int                       ADDR_W       = 16,
    parameter int                       DATA_W       = 16,
    parameter logic [NSLAVE*ADDR_W-1:0] REGION_BASE  = {16'h4c00, 16'h1000, 16'h0001, 16'h0000},
    parameter logic [NSLAVE*ADDR_W-1:0] REGION_LIMIT = {16'hffff, 16'h4bff, 16'h0002, 16'h0000},
    parameter int                       DEFAULT_SLV  = 3,
    parameter int                       TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        m_addr,
    input  logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_rd,
    input  logic                     m_wr,
    input  logic                     m_instr,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     m_busy,
    output logic                     m_ready,
    output logic                     m_err,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [NSLAVE-1:0]        s_rd,
    output logic [NSLAVE-1:0]        s_wr,
    input  logic [NSLAVE*DATA_W-1:0] s_rdata,
    input  logic [NSLAVE-1:0]        s_ready
);
    localparam int SEL_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [NSLAVE-1:0] s_rd_q, s_rd_d;
    logic [NSLAVE-1:0] s_wr_q, s_wr_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
    logic              m_ready_q, m_ready_d;
    logic              m_busy_q, m_busy_d;
`ifdef BUS_TIMEOUT_EN
    logic [7:0]        cnt_q, cnt_d;
    logic              m_err_q, m_err_d;
`endif

    logic [SEL_W-1:0]  dec_sel;
    logic [ADDR_W-1:0] dec_base;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_sel = SEL_W'(DEFAULT_SLV);
        if (!m_instr) begin
            for (int i = NSLAVE - 1; i >= 0; i--) begin
                if (m_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                    m_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W])
                    dec_sel = SEL_W'(i);
            end
        end
        dec_base = REGION_BASE[int'(dec_sel)*ADDR_W +: ADDR_W];
    end

    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[int'(sel_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        is_wr_d   = is_wr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_rd_d    = '0;
        s_wr_d    = '0;
        m_rdata_d = m_rdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
        m_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (m_rd || m_wr) begin
                    sel_d     = dec_sel;
                    is_wr_d   = m_wr;
                    s_addr_d  = m_addr - dec_base;
                    s_wdata_d = m_wdata;
                    if (m_wr) s_wr_d[dec_sel] = 1'b1;
                    else      s_rd_d[dec_sel] = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                if (sel_ready) begin
                    m_rdata_d = is_wr_q ? '0 : sel_rdata;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_WAIT;
`ifdef BUS_TIMEOUT_EN
                    if (state_q == S_REQ) begin
                        cnt_d = '0;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            S_DONE: state_d = S_HOLD;
            // A level request stays asserted past completion; wait for it to drop before re-arming.
            S_HOLD: if (!m_rd && !m_wr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        m_busy_d  = (state_d == S_REQ) || (state_d == S_WAIT);
        m_ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            is_wr_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_rd_q    <= '0;
            s_wr_q    <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            m_busy_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q     <= '0;
            m_err_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            is_wr_q   <= is_wr_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_rd_q    <= s_rd_d;
            s_wr_q    <= s_wr_d;
            m_rdata_q <= m_rdata_d;
            m_ready_q <= m_ready_d;
            m_busy_q  <= m_busy_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            m_err_q   <= m_err_d;
`endif
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_busy  = m_busy_q;
    assign m_ready = m_ready_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_rd    = s_rd_q;
    assign s_wr    = s_wr_q;
`ifdef BUS_TIMEOUT_EN
    assign m_err   = m_err_q;
`else
    assign m_err   = 1'b0;
`endif

endmodule
